// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receiver.
// FSM state encoding, parity-type codes and the 3-sample majority helper.
package uart_rx_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_START  = 3'd1;
  localparam state_t ST_DATA   = 3'd2;
  localparam state_t ST_PARITY = 3'd3;
  localparam state_t ST_STOP   = 3'd4;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  function automatic logic maj3(
    input logic a,
    input logic b,
    input logic c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter and 3-sample majority vote around mid-bit.
// bit_done strobes at edge M+1, the cycle whose own sample completes the vote.
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int OVERSAMPLE = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_rx,
  input  logic i_run,
  input  logic i_clr,
  output logic o_bit,
  output logic o_bit_done
);

  localparam int CW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam int M  = OVERSAMPLE / 2;

  localparam logic [CW-1:0] E_LO   = CW'(M - 1);
  localparam logic [CW-1:0] E_MID  = CW'(M);
  localparam logic [CW-1:0] E_HI   = CW'(M + 1);
  localparam logic [CW-1:0] E_LAST = CW'(OVERSAMPLE - 1);

  logic [CW-1:0] r_edge_cnt;
  logic [1:0]    r_samp;
  logic          w_at_samp;

  assign w_at_samp = (r_edge_cnt == E_LO) ||
                     (r_edge_cnt == E_MID);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_edge_cnt <= '0;
    end else if (i_clr || !i_run) begin
      r_edge_cnt <= '0;
    end else if (r_edge_cnt == E_LAST) begin
      r_edge_cnt <= '0;
    end else begin
      r_edge_cnt <= r_edge_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_samp <= 2'b11;
    end else if (i_run && w_at_samp) begin
      r_samp <= {r_samp[0], i_rx};
    end
  end

  // third sample is the live input, so the vote lands on edge M+1
  assign o_bit      = maj3(r_samp[1], r_samp[0], i_rx);
  assign o_bit_done = i_run && (r_edge_cnt == E_HI);

endmodule

// File: rtl/uart_rx.sv
// UART receive path: start detect, LSB-first data, optional parity, stop check.
// Define UART_RX_SYNC_EN to pass RX_IN through a 2-flop synchronizer first.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_VALID,
  output logic                  PAR_ERR,
  output logic                  STP_ERR
);

  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

  logic                  w_rx;
  state_t                r_state;
  state_t                w_next;
  logic [BW-1:0]         r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_par_en;
  logic                  r_par_typ;
  logic                  r_par_bad;
  logic                  r_break;
  logic                  w_start;
  logic                  w_run;
  logic                  w_to_idle;
  logic                  w_bit;
  logic                  w_bit_done;
  logic                  w_bit_last;
  logic                  w_par_exp;

`ifdef UART_RX_SYNC_EN
  logic [1:0] r_sync;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], RX_IN};
    end
  end

  assign w_rx = r_sync[1];
`else
  assign w_rx = RX_IN;
`endif

  // after a stop error the line must go high before a new start counts
  assign w_start    = (r_state == ST_IDLE) && !w_rx && !r_break;
  assign w_run      = (r_state != ST_IDLE) || w_start;
  assign w_to_idle  = (r_state != ST_IDLE) && (w_next == ST_IDLE);
  assign w_bit_last = (r_bit_cnt == BIT_LAST);
  assign w_par_exp  = (^r_shift) ^ (r_par_typ == PAR_ODD);

  uart_rx_sampler #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_sampler (
    .i_clk      (CLK),
    .i_rst_n    (RST),
    .i_rx       (w_rx),
    .i_run      (w_run),
    .i_clr      (w_to_idle),
    .o_bit      (w_bit),
    .o_bit_done (w_bit_done)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_start) w_next = ST_START;
      end
      ST_START: begin
        if (w_bit_done) begin
          w_next = w_bit ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_bit_done && w_bit_last) begin
          w_next = r_par_en ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (w_bit_done) w_next = ST_STOP;
      end
      ST_STOP: begin
        if (w_bit_done) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_par_en  <= 1'b0;
      r_par_typ <= PAR_EVEN;
    end else if (w_start) begin
      r_par_en  <= PAR_EN;
      r_par_typ <= PAR_TYP;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else if (w_start) begin
      r_bit_cnt <= '0;
    end else if (r_state == ST_DATA && w_bit_done) begin
      r_bit_cnt <= r_bit_cnt + 1'b1;
      r_shift   <= {w_bit, r_shift[DATA_WIDTH-1:1]};
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_par_bad <= 1'b0;
    end else if (w_start) begin
      r_par_bad <= 1'b0;
    end else if (r_state == ST_PARITY && w_bit_done) begin
      r_par_bad <= (w_bit != w_par_exp);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_break <= 1'b0;
    end else if (r_state == ST_STOP && w_bit_done && !w_bit) begin
      r_break <= 1'b1;
    end else if (r_state == ST_IDLE && w_rx) begin
      r_break <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      P_DATA     <= '0;
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
    end else begin
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
      if (r_state == ST_STOP && w_bit_done) begin
        STP_ERR <= !w_bit;
        PAR_ERR <= r_par_bad;
        if (w_bit && !r_par_bad) begin
          DATA_VALID <= 1'b1;
          P_DATA     <= r_shift;
        end
      end
    end
  end

endmodule
